// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rectangle-fill engine feeding the VGA framebuffer pixel bus.
// A small register slave holds X0/Y0/W/H/COLOR; a CTRL write with START runs
// IDLE -> SETUP -> FILL -> DONE, issuing one pixel write per granted cycle.
// Optional build macro VGA_FILL_IRQ_EN: stores CTRL.IE and drives oIRQ = DONE & IE.
//
// Framebuffer handshake: oREQ is held high for the whole FILL state; a write
// transfers in every cycle where oREQ=1 and iGNT=1 (oCS/oWR follow iGNT
// combinationally), and the engine only advances its counters in those cycles.
module vga_rect_fill #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [2:0]        iS_ADDR,
  input  logic [15:0]       iS_DATA,
  input  logic              iS_CS,
  input  logic              iS_WR,
  input  logic              iS_RD,
  output logic [15:0]       oS_DATA,
  input  logic              iGNT,
  output logic              oREQ,
  output logic [ADDR_W-1:0] oADDR,
  output logic [15:0]       oDATA,
  output logic              oCS,
  output logic              oWR,
  output logic              oIRQ,
  output logic [1:0]        oDBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_FILL  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // programmable registers
  logic [15:0] reg_x0, reg_y0, reg_w, reg_h, reg_color;
  logic        done_flag;
  logic        ie;

  // shadow copies used by the running fill
  logic [15:0]       xs, wc, hc, col, row, colour;
  logic [ADDR_W-1:0] rowbase;

  // slave decode
  logic wr_en, ctrl_wr, start_req, clr_req, abort_req;
  logic unused_rd;

  assign unused_rd = iS_RD;  // reads have no side effects; data is purely address-decoded
  assign wr_en     = iS_CS & iS_WR;
  assign ctrl_wr   = wr_en && (iS_ADDR == 3'd5);
  assign start_req = ctrl_wr & iS_DATA[0];
  assign clr_req   = ctrl_wr & iS_DATA[1];
  assign abort_req = ctrl_wr & iS_DATA[2];

  // clipped extents and empty-rectangle detection evaluated during SETUP
  logic [16:0] x_room, y_room;
  logic [15:0] wc_calc, hc_calc;
  logic        empty;
  logic        last_col, last_row, fill_active;

  // clipping arithmetic; x_room/y_room only matter when the origin is on-screen
  always_comb begin
    x_room  = 17'(H_RES) - {1'b0, reg_x0};
    y_room  = 17'(V_RES) - {1'b0, reg_y0};
    wc_calc = ({1'b0, reg_w} < x_room) ? reg_w : x_room[15:0];
    hc_calc = ({1'b0, reg_h} < y_room) ? reg_h : y_room[15:0];
    empty   = (reg_x0 >= 16'(H_RES)) || (reg_y0 >= 16'(V_RES)) ||
              (reg_w == 16'd0) || (reg_h == 16'd0);
  end

  assign last_col    = (col == wc - 16'd1);
  assign last_row    = (row == hc - 16'd1);
  assign fill_active = (state == S_FILL);

  // state register
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // next-state logic; ABORT overrides everything outside IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_req) state_nxt = S_SETUP;
      S_SETUP: state_nxt = empty ? S_DONE : S_FILL;
      S_FILL:  if (iGNT && last_col && last_row) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_req && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // register slave writes; CTRL only stores IE
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      reg_x0    <= '0;
      reg_y0    <= '0;
      reg_w     <= '0;
      reg_h     <= '0;
      reg_color <= '0;
    end else if (wr_en) begin
      case (iS_ADDR)
        3'd0:    reg_x0    <= iS_DATA;
        3'd1:    reg_y0    <= iS_DATA;
        3'd2:    reg_w     <= iS_DATA;
        3'd3:    reg_h     <= iS_DATA;
        3'd4:    reg_color <= iS_DATA;
        default: ;
      endcase
    end
  end

`ifdef VGA_FILL_IRQ_EN
  // interrupt enable bit, rewritten by every CTRL write
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)      ie <= 1'b0;
    else if (ctrl_wr) ie <= iS_DATA[3];
  end
  assign oIRQ = done_flag & ie;
`else
  assign ie   = 1'b0;
  assign oIRQ = 1'b0;
`endif

  // sticky DONE: the DONE-state set beats a same-cycle clear; ABORT suppresses the set
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)                                done_flag <= 1'b0;
    else if ((state == S_DONE) && !abort_req)   done_flag <= 1'b1;
    else if (clr_req)                           done_flag <= 1'b0;
  end

  // shadow latch in SETUP and raster counters advanced on granted FILL cycles
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      xs      <= '0;
      wc      <= '0;
      hc      <= '0;
      col     <= '0;
      row     <= '0;
      colour  <= '0;
      rowbase <= '0;
    end else if (state == S_SETUP) begin
      xs      <= reg_x0;
      wc      <= wc_calc;
      hc      <= hc_calc;
      col     <= '0;
      row     <= '0;
      colour  <= reg_color;
      rowbase <= ADDR_W'(32'(reg_y0) * H_RES);
    end else if (fill_active && iGNT) begin
      if (last_col) begin
        col     <= '0;
        row     <= row + 16'd1;
        rowbase <= rowbase + ADDR_W'(H_RES);
      end else begin
        col <= col + 16'd1;
      end
    end
  end

  // framebuffer bus: idle values outside FILL so reset forces them low at once
  always_comb begin
    oREQ  = fill_active;
    oCS   = fill_active & iGNT;
    oWR   = fill_active & iGNT;
    oADDR = '0;
    oDATA = '0;
    if (fill_active) begin
      oADDR = rowbase + ADDR_W'(xs) + ADDR_W'(col);
      oDATA = colour;
    end
  end

  // register read mux, combinational from the address
  always_comb begin
    oS_DATA = '0;
    case (iS_ADDR)
      3'd0:    oS_DATA = reg_x0;
      3'd1:    oS_DATA = reg_y0;
      3'd2:    oS_DATA = reg_w;
      3'd3:    oS_DATA = reg_h;
      3'd4:    oS_DATA = reg_color;
      3'd5:    oS_DATA = {12'd0, ie, 1'b0, done_flag, (state != S_IDLE)};
      default: oS_DATA = '0;
    endcase
  end

  assign oDBG_STATE = state;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: table of directed fills, hand-written corner
// sequences (stall, abort, re-program, reset mid-fill, IRQ) and random fills
// checked against a raster-loop model of the rectangle.
module tb_vga_rect_fill;
  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;
  localparam int W      = ADDR_W + 16;
`ifdef VGA_FILL_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic              iCLK, iRST_N;
  logic [2:0]        iS_ADDR;
  logic [15:0]       iS_DATA;
  logic              iS_CS, iS_WR, iS_RD;
  logic [15:0]       oS_DATA;
  logic              iGNT, oREQ, oCS, oWR, oIRQ;
  logic [ADDR_W-1:0] oADDR;
  logic [15:0]       oDATA;
  logic [1:0]        oDBG_STATE;

  vga_rect_fill #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iS_ADDR(iS_ADDR), .iS_DATA(iS_DATA), .iS_CS(iS_CS), .iS_WR(iS_WR), .iS_RD(iS_RD),
    .oS_DATA(oS_DATA), .iGNT(iGNT), .oREQ(oREQ), .oADDR(oADDR), .oDATA(oDATA),
    .oCS(oCS), .oWR(oWR), .oIRQ(oIRQ), .oDBG_STATE(oDBG_STATE)
  );

  // clock / reset
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_checks = 0;
  int n_err    = 0;
  int viol     = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  // write monitor: sample mid-cycle, the write lands at the following edge
  always @(negedge iCLK) begin
    if (iRST_N && oWR) got_q.push_back({oADDR, oDATA});
    if ((oWR && !iGNT) || (oCS !== oWR)) viol++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic reg_write(input int addr, input logic [15:0] data);
    iS_ADDR = 3'(addr); iS_DATA = data; iS_CS = 1'b1; iS_WR = 1'b1;
    @(posedge iCLK); #1;
    iS_CS = 1'b0; iS_WR = 1'b0;
  endtask

  task automatic reg_read_check(input string name, input int addr, input logic [15:0] exp);
    iS_ADDR = 3'(addr); iS_CS = 1'b1; iS_RD = 1'b1;
    #1;
    check(name, 64'(oS_DATA), 64'(exp));
    iS_CS = 1'b0; iS_RD = 1'b0; iS_ADDR = 3'd5;
  endtask

  // reference model: every on-screen pixel of the rectangle, in raster order
  task automatic model_fill(input int x0, input int y0, input int w, input int h, input logic [15:0] color);
    exp_q.delete();
    for (int y = y0; y < y0 + h && y < V_RES; y++)
      for (int x = x0; x < x0 + w && x < H_RES; x++)
        exp_q.push_back({ADDR_W'(y * H_RES + x), color});
  endtask

  task automatic start_fill(input int x0, input int y0, input int w, input int h,
                            input logic [15:0] color, input logic [15:0] ctrl);
    reg_write(0, 16'(x0)); reg_write(1, 16'(y0)); reg_write(2, 16'(w));
    reg_write(3, 16'(h));  reg_write(4, color);
    got_q.delete(); viol = 0;
    iGNT = 1'b1;
    reg_write(5, ctrl);
  endtask

  // gmode: 0 = always granted, 1 = toggling, 2 = random
  task automatic wait_done(input int gmode, output int cycles);
    cycles = 0;
    iS_ADDR = 3'd5;
    while (cycles < 5000) begin
      @(posedge iCLK); #1;
      cycles++;
      if (gmode == 1) iGNT = ~iGNT;
      else if (gmode == 2) iGNT = ($urandom_range(0, 3) != 0);
      if (oS_DATA[1]) break;
    end
    if (!oS_DATA[1]) check("fill_timeout", 64'(oS_DATA[1]), 64'd1);
    iGNT = 1'b0;
  endtask

  task automatic compare_writes(input string name);
    check({name, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", name, i), (i < got_q.size()) ? 64'(got_q[i]) : 64'hdead, 64'(exp_q[i]));
  endtask

  typedef struct {
    int x0, y0, w, h;
    logic [15:0] color;
    int exp_n, exp_first, exp_last;
  } vec_t;

  vec_t vecs[6];
  int   cyc;

  initial begin
    iRST_N = 1'b0; iS_ADDR = '0; iS_DATA = '0; iS_CS = 0; iS_WR = 0; iS_RD = 0; iGNT = 0;

    // reset state
    #2;
    check("rst_outputs", 64'({oREQ, oCS, oWR, oIRQ}), 64'd0);
    check("rst_addr_data", 64'({oADDR, oDATA}), 64'd0);
    repeat (2) @(posedge iCLK);
    #1 iRST_N = 1'b1;
    for (int a = 0; a < 8; a++) reg_read_check($sformatf("rst_reg%0d", a), a, 16'h0);

    // directed table
    vecs[0] = '{10, 2, 3, 2, 16'h0001, 6, 1290, 1932};
    vecs[1] = '{638, 479, 5, 5, 16'h00F0, 2, 307198, 307199};
    vecs[2] = '{640, 0, 4, 4, 16'h1234, 0, 0, 0};
    vecs[3] = '{5, 5, 0, 3, 16'h5555, 0, 0, 0};
    vecs[4] = '{0, 0, 1, 1, 16'hFFFF, 1, 0, 0};
    vecs[5] = '{639, 0, 1, 3, 16'hA5A5, 3, 639, 1919};
    foreach (vecs[i]) begin
      model_fill(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color);
      start_fill(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].color, 16'h0003);
      wait_done(0, cyc);
      check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_n + 2));
      check($sformatf("vec%0d_n", i), 64'(got_q.size()), 64'(vecs[i].exp_n));
      if (vecs[i].exp_n > 0 && got_q.size() > 0) begin
        check($sformatf("vec%0d_first", i), 64'(got_q[0][W-1:16]), 64'(vecs[i].exp_first));
        check($sformatf("vec%0d_last", i), 64'(got_q[got_q.size()-1][W-1:16]), 64'(vecs[i].exp_last));
      end
      compare_writes($sformatf("vec%0d", i));
    end

    // grant stall: 4x1 with toggling grant
    model_fill(20, 3, 4, 1, 16'h0C0C);
    start_fill(20, 3, 4, 1, 16'h0C0C, 16'h0003);
    wait_done(1, cyc);
    compare_writes("stall");
    check("stall_wr_without_gnt", 64'(viol), 64'd0);

    // abort after 3 writes of a 10x10 fill
    start_fill(0, 0, 10, 10, 16'h00AA, 16'h0003);
    repeat (3) begin @(posedge iCLK); #1; end
    reg_write(5, 16'h0004);
    reg_read_check("abort_busy_done", 5, 16'h0000);
    repeat (5) begin @(posedge iCLK); #1; end
    model_fill(0, 0, 3, 1, 16'h00AA);
    compare_writes("abort");
    reg_read_check("abort_still_idle", 5, 16'h0000);

    // re-program W while busy: running fill keeps width 5
    model_fill(100, 0, 5, 1, 16'h0F0F);
    start_fill(100, 0, 5, 1, 16'h0F0F, 16'h0003);
    repeat (2) begin @(posedge iCLK); #1; end
    reg_write(2, 16'd1);
    wait_done(0, cyc);
    compare_writes("reprog");
    reg_read_check("reprog_w_reg", 2, 16'd1);

    // reset mid-fill: bus drops before the next edge
    start_fill(0, 0, 10, 10, 16'h3333, 16'h0003);
    repeat (3) begin @(posedge iCLK); #1; end
    check("midfill_req_before", 64'(oREQ), 64'd1);
    iRST_N = 1'b0;
    #1;
    check("midfill_rst_wr_req", 64'({oWR, oREQ, oCS}), 64'd0);
    @(posedge iCLK); #1;
    iRST_N = 1'b1;
    for (int a = 0; a < 6; a++) reg_read_check($sformatf("midfill_reg%0d", a), a, 16'h0);
    iGNT = 1'b0;

    // interrupt: IE=1, complete a fill, then clear DONE
    reg_write(5, 16'h0008);
    start_fill(1, 1, 1, 1, 16'h0001, 16'h000B);
    wait_done(0, cyc);
    check("irq_with_done", 64'(oIRQ), 64'(IRQ_ON));
    reg_read_check("irq_ctrl_done", 5, IRQ_ON ? 16'h000A : 16'h0002);
    reg_write(5, 16'h000A);
    check("irq_cleared", 64'(oIRQ), 64'd0);
    reg_read_check("irq_ctrl_cleared", 5, IRQ_ON ? 16'h0008 : 16'h0000);
    reg_write(5, 16'h0000);

    // random register readback
    for (int r = 0; r < 5; r++) begin
      logic [15:0] v;
      v = 16'($urandom);
      reg_write(r, v);
      reg_read_check($sformatf("rand_reg%0d", r), r, v);
    end

    // random fills near and away from the screen edges
    for (int k = 0; k < 15; k++) begin
      int x0, y0, w, h, gm;
      logic [15:0] c;
      x0 = ($urandom_range(0, 1) != 0) ? $urandom_range(630, 645) : $urandom_range(0, 639);
      y0 = ($urandom_range(0, 1) != 0) ? $urandom_range(470, 485) : $urandom_range(0, 479);
      w  = $urandom_range(0, 6);
      h  = $urandom_range(0, 6);
      gm = $urandom_range(0, 2);
      c  = 16'($urandom);
      model_fill(x0, y0, w, h, c);
      start_fill(x0, y0, w, h, c, 16'h0003);
      wait_done(gm, cyc);
      compare_writes($sformatf("rand%0d", k));
      if (gm == 0) check($sformatf("rand%0d_cycles", k), 64'(cyc), 64'(exp_q.size() + 2));
      check($sformatf("rand%0d_gnt", k), 64'(viol), 64'd0);
    end

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/vga_rect_fill.md
Name: vga_rect_fill

Overview:
- Hardware rectangle-fill engine that sits directly upstream of the binary VGA framebuffer controller.
- NIOS programs a rectangle (x0, y0, width, height, colour) through a small register slave, then starts the engine.
- The engine issues one framebuffer write per granted cycle on the controller's pixel bus: address = y*H_RES + x.
- A bus arbiter/mux between NIOS and this engine drives iGNT.

Parameters:
- H_RES, 640, pixels per line; also the address stride per row.
- V_RES, 480, lines per frame.
- ADDR_W, 19, framebuffer address width. H_RES*V_RES must be ≤ 2^ADDR_W.

Ports:
- iCLK  in  1  system clock, same clock as the VGA controller bus side.
- iRST_N  in  1  reset, asynchronous, active-low.
- iS_ADDR  in  3  register select.
- iS_DATA  in  16  register write data.
- iS_CS  in  1  slave chip select.
- iS_WR  in  1  slave write strobe; effective when iS_CS=1.
- iS_RD  in  1  slave read strobe; effective when iS_CS=1.
- oS_DATA  out  16  register read data, combinational from iS_ADDR.
- iGNT  in  1  arbiter grant for the framebuffer bus.
- oREQ  out  1  framebuffer bus request.
- oADDR  out  ADDR_W  framebuffer pixel address.
- oDATA  out  16  pixel write data.
- oCS  out  1  framebuffer chip select.
- oWR  out  1  framebuffer write strobe.
- oIRQ  out  1  completion interrupt (see Optional Feature).

Behaviour:
- Register map (16-bit):
  - 0 X0, 1 Y0, 2 W, 3 H, 4 COLOR. All are read/write and reset to 0.
  - 5 CTRL, write side: bit0 START, bit1 clear DONE, bit2 ABORT, bit3 IE.
  - 5 CTRL, read side: bit0 BUSY, bit1 DONE (sticky), bit3 IE.
  - 6 and 7 read as 0; writes to them are ignored.
- Reset values:
  - State IDLE; DONE=0, IE=0.
  - oREQ=0, oCS=0, oWR=0, oADDR=0, oDATA=0, oIRQ=0.
- State machine IDLE → SETUP → FILL → DONE → IDLE.
  - IDLE: a CTRL write with bit0=1 enters SETUP next cycle. START while not IDLE is ignored.
  - SETUP (1 cycle):
    - Latch shadow copies: xs=X0, ys=Y0, col=0, row=0, colour=COLOR.
    - Clip: wc = min(W, H_RES-X0), hc = min(H, V_RES-Y0).
    - Compute rowbase = Y0*H_RES (multiply allowed).
    - If X0≥H_RES, Y0≥V_RES, W=0 or H=0: go to DONE with no writes. Otherwise go to FILL.
  - FILL:
    - oREQ=1 throughout.
    - oADDR = rowbase+xs+col (ADDR_W bits), oDATA = colour.
    - oCS = oWR = iGNT, combinational, so the write lands in the granted cycle.
    - On a granted cycle: col++. When col==wc-1: col=0, row++, rowbase += H_RES.
    - The write with row==hc-1 and col==wc-1 is the last; go to DONE.
    - iGNT=0 stalls all counters; nothing advances and no write occurs.
  - DONE (1 cycle): set DONE=1, go to IDLE.
- BUSY is 1 in SETUP, FILL and DONE.
- Programming while busy:
  - Writes to X0..COLOR while BUSY update the registers only. The running fill uses its shadow copies.
  - The new values apply at the next START.
- Simultaneous events:
  - ABORT in any non-IDLE state returns to IDLE next cycle and leaves DONE unchanged. The write granted in the abort cycle still completes.
  - Clear-DONE and a DONE-state set in the same cycle: the set wins.
  - Clear-DONE and START in the same write are both honoured.
- Total writes = wc*hc. With iGNT held at 1, START-write to DONE=1 takes wc*hc+2 cycles.
- Reset asserted mid-fill: outputs go to their reset values immediately (asynchronous); the fill is lost.

Optional Feature:
- Macro: VGA_FILL_IRQ_EN.
- Defined: oIRQ = DONE & IE, a level output. It clears on a clear-DONE write or on IE=0.
- Undefined: oIRQ is tied 0, CTRL bit3 is not stored and reads 0.

Test Plan:
- Basic fill:
  - Stimulus: X0=10, Y0=2, W=3, H=2, COLOR=0x0001, START, iGNT=1.
  - Required: exactly 6 writes, at addresses 1290,1291,1292,1930,1931,1932, all with data 0x0001. DONE=1 at 8 cycles after the START write.
- Clipping:
  - Stimulus: X0=638, Y0=479, W=5, H=5.
  - Required: writes only at 307198 and 307199.
  - Stimulus: X0=640, then START.
  - Required: no writes; DONE=1 after 2 cycles.
- Grant stall:
  - Stimulus: 4x1 fill with iGNT toggling 1,0,1,0,...
  - Required: oWR only in iGNT=1 cycles; addresses are sequential with no duplicates or skips; 4 writes total.
- Abort and re-program:
  - Stimulus: ABORT after 3 writes of a 10x10 fill.
  - Required: BUSY=0 next cycle, DONE stays 0, no further writes.
  - Stimulus: write W=1 during a fill.
  - Required: the running fill still completes its originally programmed width.
- Reset mid-FILL:
  - Stimulus: assert iRST_N=0 during FILL.
  - Required: oWR=0 and oREQ=0 asynchronously, before the next clock edge; all registers read 0 after release.
- IRQ build (with VGA_FILL_IRQ_EN):
  - Stimulus: IE=1 and complete a fill, then write CTRL with bit1=1.
  - Required: oIRQ rises with DONE, then clears the next cycle.
  - Stimulus: the same sequence in a build without the macro.
  - Required: oIRQ stays 0.
